// File: rtl/map_ss_engine.sv
// Mapper save-state engine: snapshots mapper registers to a buffer (save) or restores them (load).
// Optional post-load readback verify pass is enabled by defining MAP_SS_VERIFY_EN.
module map_ss_engine #(
    parameter int unsigned REG_CNT = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_save,
    input  logic       start_load,
    output logic       busy,
    output logic       done,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic       m2,
    output logic [7:0] ss_wdat,
    input  logic [7:0] ss_rdat,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdat,
    output logic       mem_we,
    input  logic [7:0] mem_rdat,
    output logic       err,
    output logic [7:0] err_addr
);
    localparam int unsigned AW = 8;
    localparam logic [AW-1:0] LAST_SAVE = AW'(REG_CNT - 1);
    // map_idx (top register) is read-only, so load and verify stop one short
    localparam logic [AW-1:0] LAST_LOAD = AW'(REG_CNT - 2);

    typedef enum logic [3:0] {
        IDLE, DONE, S_SET, S_HI, S_LO, L_FET, L_SET, L_HI, L_LO
`ifdef MAP_SS_VERIFY_EN
        , V_FET, V_SET, V_HI, V_LO
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ss_we_q, ss_we_d;
    logic [AW-1:0] ss_addr_q, ss_addr_d;
    logic          m2_q, m2_d;
    logic [7:0]    wdat_q, wdat_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdat_q, mem_wdat_d;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ss_we_q    <= 1'b0;
            ss_addr_q  <= '0;
            m2_q       <= 1'b0;
            wdat_q     <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wdat_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ss_we_q    <= ss_we_d;
            ss_addr_q  <= ss_addr_d;
            m2_q       <= m2_d;
            wdat_q     <= wdat_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wdat_q <= mem_wdat_d;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (start_save) begin
                    state_d = S_SET;
                    idx_d   = '0;
                end else if (start_load) begin
                    state_d = L_FET;
                    idx_d   = '0;
                end
            end
            S_SET: state_d = S_HI;
            S_HI:  state_d = S_LO;
            S_LO: begin
                if (idx_q == LAST_SAVE) begin
                    state_d = DONE;
                end else begin
                    state_d = S_SET;
                    idx_d   = idx_q + AW'(1);
                end
            end
            L_FET: state_d = L_SET;
            L_SET: state_d = L_HI;
            L_HI:  state_d = L_LO;
            L_LO: begin
                if (idx_q == LAST_LOAD) begin
`ifdef MAP_SS_VERIFY_EN
                    state_d = V_FET;
                    idx_d   = '0;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = L_FET;
                    idx_d   = idx_q + AW'(1);
                end
            end
`ifdef MAP_SS_VERIFY_EN
            V_FET: state_d = V_SET;
            V_SET: state_d = V_HI;
            V_HI:  state_d = V_LO;
            V_LO: begin
                if (idx_q == LAST_LOAD) begin
                    state_d = DONE;
                end else begin
                    state_d = V_FET;
                    idx_d   = idx_q + AW'(1);
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state so they register in step with it
    always_comb begin
        busy_d     = !(state_d inside {IDLE, DONE});
        done_d     = (state_d == DONE);
        m2_d       = (state_d inside {S_HI, L_HI
`ifdef MAP_SS_VERIFY_EN
                                      , V_HI
`endif
                                      });
        ss_we_d    = (state_d inside {L_SET, L_HI, L_LO});
        ss_addr_d  = busy_d ? idx_d : ss_addr_q;
        mem_addr_d = busy_d ? idx_d : mem_addr_q;
        mem_we_d   = (state_d == S_LO);
        mem_wdat_d = mem_we_d ? ss_rdat : mem_wdat_q;
        // Buffer data arrives in L_SET; pass it through then hold through L_LO
        wdat_d     = (state_q == L_SET) ? mem_rdat : wdat_q;
    end

`ifdef MAP_SS_VERIFY_EN
    logic          err_q, err_d;
    logic [AW-1:0] err_addr_q, err_addr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Sticky first-mismatch capture, cleared by an accepted start
    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (state_q == IDLE && (start_save || start_load)) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end else if (state_q == V_LO && !err_q && ss_rdat != mem_rdat) begin
            err_d      = 1'b1;
            err_addr_d = idx_q;
        end
    end

    assign err      = err_q;
    assign err_addr = err_addr_q;
`else
    assign err      = 1'b0;
    assign err_addr = '0;
`endif

    assign busy     = busy_q;
    assign ss_act   = busy_q;
    assign done     = done_q;
    assign ss_we    = ss_we_q;
    assign ss_addr  = ss_addr_q;
    assign m2       = m2_q;
    assign ss_wdat  = wdat_d;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_wdat = mem_wdat_q;

endmodule

// File: tb/tb_map_ss_engine.sv
// Bench for map_ss_engine: mapper and buffer models with scoreboard queues for buffer writes,
// mapper writes and done timing. Honours MAP_SS_VERIFY_EN the same way as the design.
module tb_map_ss_engine;
    localparam int R = 128;
`ifdef MAP_SS_VERIFY_EN
    localparam int VER_CYC = 4 * (R - 1);
`else
    localparam int VER_CYC = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_save = 1'b0;
    logic       start_load = 1'b0;
    logic       busy, done, ss_act, ss_we, m2, mem_we, err;
    logic [7:0] ss_addr, ss_wdat, ss_rdat, mem_addr, mem_wdat, mem_rdat, err_addr;

    always #5 clk = ~clk;

    map_ss_engine #(.REG_CNT(R)) dut (
        .clk(clk), .rst(rst), .start_save(start_save), .start_load(start_load),
        .busy(busy), .done(done), .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr),
        .m2(m2), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat), .mem_addr(mem_addr),
        .mem_wdat(mem_wdat), .mem_we(mem_we), .mem_rdat(mem_rdat),
        .err(err), .err_addr(err_addr)
    );

    logic [7:0]  mapper_reg [256];
    bit          force_rd   [256];
    logic [7:0]  bufm       [256];
    int          n_vec = 0, n_err = 0;
    int          cyc = 0, done_cnt = 0, we_cnt = 0;
    int          exp_done [$];
    logic [15:0] exp_mem  [$];
    logic [15:0] exp_map  [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < budget) begin
            tick();
            k++;
        end
        chk("done_seen", 32'(done_cnt - d0), 32'd1);
    endtask

    // Mapper readback, with per-register forcing to provoke verify mismatches
    assign ss_rdat = force_rd[ss_addr] ? 8'h00 : mapper_reg[ss_addr];

    // Buffer RAM with one-clock read latency
    always @(posedge clk) begin
        if (mem_we) bufm[mem_addr] <= mem_wdat;
        mem_rdat <= bufm[mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Done and buffer-write scoreboards
    always @(posedge clk) begin
        logic [31:0] e;
        #1;
        if (done) begin
            done_cnt++;
            e = (exp_done.size() != 0) ? 32'(exp_done.pop_front()) : 32'hFFFF_FFFF;
            chk("done_cyc", 32'(cyc), e);
        end
        if (mem_we) begin
            we_cnt++;
            e = (exp_mem.size() != 0) ? 32'(exp_mem.pop_front()) : 32'hFFFF_FFFF;
            chk("save_wr", 32'({mem_addr, mem_wdat}), e);
        end
    end

    // Mapper latches cpu data on the m2 falling edge when in save-state write mode
    always @(negedge m2) begin
        logic [31:0] e;
        #1;
        if (ss_we && ss_act) begin
            mapper_reg[ss_addr] = ss_wdat;
            e = (exp_map.size() != 0) ? 32'(exp_map.pop_front()) : 32'hFFFF_FFFF;
            chk("load_wr", 32'({ss_addr, ss_wdat}), e);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int d0;
        logic [7:0] old127;

        for (int i = 0; i < 256; i++) begin
            mapper_reg[i] = 8'($urandom);
            force_rd[i]   = 1'b0;
            bufm[i]       = 8'h00;
        end

        // Reset values
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ss_act", 32'(ss_act), 0);
        chk("rst_ss_we", 32'(ss_we), 0);
        chk("rst_ss_addr", 32'(ss_addr), 0);
        chk("rst_m2", 32'(m2), 0);
        chk("rst_ss_wdat", 32'(ss_wdat), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdat", 32'(mem_wdat), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_err_addr", 32'(err_addr), 0);
        rst = 1'b0;
        tick();

        // Save, with simultaneous start_load and a second start_load while busy
        mapper_reg[0]   = 8'h15;
        mapper_reg[R-1] = 8'h07;
        for (int i = 0; i < R; i++) exp_mem.push_back({8'(i), mapper_reg[i]});
        we_cnt = 0;
        d0     = done_cnt;
        n0     = cyc;
        exp_done.push_back(n0 + 1 + 3 * R);
        start_save = 1'b1;
        start_load = 1'b1;
        tick();
        start_save = 1'b0;
        start_load = 1'b0;
        chk("save_busy", 32'(busy), 1);
        chk("save_no_we", 32'(ss_we), 0);
        repeat (10) tick();
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        wait_done(3 * R + 20);
        repeat (6) tick();
        chk("save_buf0", 32'(bufm[0]), 32'h15);
        chk("save_buf127", 32'(bufm[R-1]), 32'h07);
        chk("save_we_cnt", 32'(we_cnt), 32'(R));
        chk("save_exp_left", 32'(exp_mem.size()), 0);
        chk("save_one_done", 32'(done_cnt - d0), 1);
        chk("save_idle", 32'(busy), 0);

        // Load into mapper; map_idx must not be written
        for (int i = 0; i < R; i++) bufm[i] = 8'($urandom);
        bufm[0] = 8'h13;
        old127  = mapper_reg[R-1];
        for (int i = 0; i < R - 1; i++) exp_map.push_back({8'(i), bufm[i]});
        n0 = cyc;
        exp_done.push_back(n0 + 1 + 4 * (R - 1) + VER_CYC);
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        chk("load_busy", 32'(busy), 1);
        wait_done(8 * R + 20);
        repeat (3) tick();
        chk("load_reg0", 32'(mapper_reg[0]), 32'h13);
        chk("load_reg127_kept", 32'(mapper_reg[R-1]), 32'(old127));
        chk("load_exp_left", 32'(exp_map.size()), 0);
        chk("load_err", 32'(err), 0);

        // Reset mid-load: abort with no done
        for (int i = 0; i < R - 1; i++) exp_map.push_back({8'(i), bufm[i]});
        n0 = cyc;
        d0 = done_cnt;
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        while (cyc < n0 + 50) tick();
        chk("abort_pre_we", 32'(ss_we), 1);
        rst = 1'b1;
        tick();
        chk("abort_m2", 32'(m2), 0);
        chk("abort_ss_we", 32'(ss_we), 0);
        chk("abort_ss_act", 32'(ss_act), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        rst = 1'b0;
        repeat (30) tick();
        chk("abort_still_idle", 32'(busy), 0);
        chk("abort_no_done", 32'(done_cnt - d0), 0);
        exp_map.delete();

        // Load with forced readback mismatches at idx 5 and 9
        for (int i = 0; i < R; i++) bufm[i] = 8'hAA;
        force_rd[5] = 1'b1;
        force_rd[9] = 1'b1;
        for (int i = 0; i < R - 1; i++) exp_map.push_back({8'(i), 8'hAA});
        n0 = cyc;
        exp_done.push_back(n0 + 1 + 4 * (R - 1) + VER_CYC);
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        wait_done(8 * R + 20);
        repeat (3) tick();
`ifdef MAP_SS_VERIFY_EN
        chk("verify_err", 32'(err), 1);
        chk("verify_err_addr", 32'(err_addr), 5);
`else
        chk("noverify_err", 32'(err), 0);
        chk("noverify_err_addr", 32'(err_addr), 0);
`endif
        chk("verify_exp_left", 32'(exp_map.size()), 0);

        // New start clears the error flags in the first busy clock
        force_rd[5] = 1'b0;
        force_rd[9] = 1'b0;
        for (int i = 0; i < R; i++) exp_mem.push_back({8'(i), mapper_reg[i]});
        n0 = cyc;
        exp_done.push_back(n0 + 1 + 3 * R);
        start_save = 1'b1;
        tick();
        start_save = 1'b0;
        chk("restart_busy", 32'(busy), 1);
        chk("restart_err", 32'(err), 0);
        chk("restart_err_addr", 32'(err_addr), 0);
        wait_done(3 * R + 20);
        repeat (3) tick();
        chk("restart_exp_left", 32'(exp_mem.size()), 0);
        chk("done_exp_left", 32'(exp_done.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
